msync_lock: RTL and testbench

- Downstream of the m-sequence correlator.
- Consumes the 8-bit correlation score the correlator produces every clock for the 31-chip template (full match 62, full inverse match 0).
- Acquires and tracks the 31-sample peak period with a SEARCH/VERIFY/LOCK state machine.
- While locked, emits one demodulated data bit per period: a positive peak gives 1, an inverted peak gives 0.

---
 rtl/msync_lock.sv | 152 +++++++++++++++
 tb/tb_msync_lock.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/msync_lock.sv
// msync_lock: peak-period acquisition, tracking and bit demodulation for m-sequence correlation scores.
// Optional stats outputs (bit_count, loss_count) are built when MSYNC_STATS_EN is defined.
module msync_lock #(
  parameter int PERIOD    = 31,
  parameter int HI_TH     = 58,
  parameter int LO_TH     = 4,
  parameter int CONFIRM_N = 3,
  parameter int MISS_MAX  = 2,
  parameter int CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  corr,
  input  logic        corr_en,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        locked,
  output logic [1:0]  state,
`ifdef MSYNC_STATS_EN
  output logic [15:0] bit_count,
  output logic [15:0] loss_count,
`endif
  output logic [1:0]  miss_cnt
);

  localparam int CF_W = $clog2(CONFIRM_N + 1);

  localparam logic [7:0]       HI      = 8'(HI_TH);
  localparam logic [7:0]       LO      = 8'(LO_TH);
  localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CF_W-1:0]  CF_LAST = CF_W'(CONFIRM_N - 1);
  localparam logic [1:0]       MS_LAST = 2'(MISS_MAX - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } st_t;

  st_t              st;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_nx;
  logic [CF_W-1:0]  confirm;

  logic pos;
  logic neg;
  logic peak;
  logic expected;
  logic bit_hit;
  logic loss_hit;

  always_comb begin
    pos      = (corr >= HI);
    neg      = (corr <= LO);
    peak     = pos | neg;
    expected = (phase == P_LAST);
    phase_nx = expected ? '0 : phase + CNT_W'(1);
  end

  // Qualified lock-state events, shared by the FSM and the stats counters
  always_comb begin
    bit_hit  = corr_en && (st == LOCK) && expected && peak;
    loss_hit = corr_en && (st == LOCK) && expected && !peak
               && (miss_cnt == MS_LAST);
  end

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= SEARCH;
      phase     <= '0;
      confirm   <= '0;
      miss_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (corr_en) begin
        unique case (st)
          SEARCH: begin
            phase <= '0;
            if (peak) begin
              st      <= VERIFY;
              confirm <= CF_W'(1);
            end
          end
          VERIFY: begin
            phase <= phase_nx;
            if (expected) begin
              if (!peak) begin
                st      <= SEARCH;
                confirm <= '0;
                phase   <= '0;
              end else if (confirm == CF_LAST) begin
                st       <= LOCK;
                locked   <= 1'b1;
                miss_cnt <= '0;
                confirm  <= '0;
              end else begin
                confirm <= confirm + CF_W'(1);
              end
            end
          end
          LOCK: begin
            phase <= phase_nx;
            if (expected) begin
              if (peak) begin
                bit_valid <= 1'b1;
                bit_out   <= pos;
                miss_cnt  <= '0;
              end else if (miss_cnt == MS_LAST) begin
                st       <= SEARCH;
                locked   <= 1'b0;
                miss_cnt <= '0;
                phase    <= '0;
              end else begin
                miss_cnt <= miss_cnt + 2'd1;
              end
            end
          end
          default: begin
            st       <= SEARCH;
            phase    <= '0;
            confirm  <= '0;
            miss_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MSYNC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count  <= '0;
      loss_count <= '0;
    end else begin
      if (bit_hit && (bit_count != 16'hFFFF))
        bit_count <= bit_count + 16'd1;
      if (loss_hit && (loss_count != 16'hFFFF))
        loss_count <= loss_count + 16'd1;
    end
  end
`else
  logic unused_ev;
  assign unused_ev = bit_hit ^ loss_hit;
`endif

endmodule

// File: tb/tb_msync_lock.sv
// Directed bench for msync_lock: acquisition, decode, misses, gaps, async reset.
// Expected values are hand-derived from sample indices.
module tb_msync_lock;

  logic       clk;
  logic       rst_n;
  logic [7:0] corr;
  logic       corr_en;
  logic       bit_out;
  logic       bit_valid;
  logic       locked;
  logic [1:0] state;
  logic [1:0] miss_cnt;
`ifdef MSYNC_STATS_EN
  logic [15:0] bit_count;
  logic [15:0] loss_count;
`endif

  int n_chk;
  int n_pass;
  int n_fail;
  int idx;

  msync_lock dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .corr      (corr),
    .corr_en   (corr_en),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .locked    (locked),
    .state     (state),
`ifdef MSYNC_STATS_EN
    .bit_count (bit_count),
    .loss_count(loss_count),
`endif
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic samp(input logic [7:0] c);
    corr    = c;
    corr_en = 1'b1;
    @(posedge clk);
    #1;
    idx++;
  endtask

  task automatic base_until(input int t);
    while (idx < t) begin
      samp(8'd31);
    end
  endtask

  task automatic gap(input int n);
    corr    = 8'd62;
    corr_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk("gap_no_strobe", {15'd0, bit_valid}, 16'd0);
  endtask

  task automatic reset_dut();
    corr_en = 1'b0;
    corr    = 8'd31;
    rst_n   = 1'b0;
    #12;
    chk("rst_state", {14'd0, state}, 16'd0);
    chk("rst_locked", {15'd0, locked}, 16'd0);
    rst_n = 1'b1;
    idx   = 0;
  endtask

  task automatic acquire();
    base_until(10);
    samp(8'd62);
    chk("acq_verify", {14'd0, state}, 16'd1);
    base_until(41);
    samp(8'd62);
    base_until(72);
    samp(8'd62);
    chk("acq_locked", {15'd0, locked}, 16'd1);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    n_fail  = 0;
    idx     = 0;
    rst_n   = 1'b0;
    corr    = 8'd31;
    corr_en = 1'b0;

    // reset state
    reset_dut();
    chk("rst_miss", {14'd0, miss_cnt}, 16'd0);
    chk("rst_bv", {15'd0, bit_valid}, 16'd0);
    chk("rst_bo", {15'd0, bit_out}, 16'd0);

    // acquisition and decode
    base_until(10);
    samp(8'd62);
    chk("a_st10", {14'd0, state}, 16'd1);
    chk("a_bv10", {15'd0, bit_valid}, 16'd0);
    base_until(41);
    samp(8'd62);
    chk("a_st41", {14'd0, state}, 16'd1);
    chk("a_lk41", {15'd0, locked}, 16'd0);
    base_until(72);
    samp(8'd62);
    chk("a_lk72", {15'd0, locked}, 16'd1);
    chk("a_st72", {14'd0, state}, 16'd2);
    chk("a_bv72", {15'd0, bit_valid}, 16'd0);
    base_until(103);
    samp(8'd0);
    chk("d_bv103", {15'd0, bit_valid}, 16'd1);
    chk("d_bo103", {15'd0, bit_out}, 16'd0);
    samp(8'd31);
    chk("d_bv104", {15'd0, bit_valid}, 16'd0);
    base_until(134);
    samp(8'd62);
    chk("d_bv134", {15'd0, bit_valid}, 16'd1);
    chk("d_bo134", {15'd0, bit_out}, 16'd1);
    samp(8'd31);
    chk("d_bv135", {15'd0, bit_valid}, 16'd0);
    chk("d_hold135", {15'd0, bit_out}, 16'd1);

    // false acquisition, off-phase peaks ignored
    reset_dut();
    base_until(10);
    samp(8'd62);
    chk("f_st10", {14'd0, state}, 16'd1);
    base_until(41);
    samp(8'd31);
    chk("f_st41", {14'd0, state}, 16'd0);
    base_until(50);
    samp(8'd62);
    chk("f_st50", {14'd0, state}, 16'd1);
    base_until(60);
    samp(8'd62);
    chk("f_off60", {14'd0, state}, 16'd1);
    base_until(81);
    samp(8'd62);
    chk("f_st81", {14'd0, state}, 16'd1);
    base_until(112);
    samp(8'd62);
    chk("f_lk112", {15'd0, locked}, 16'd1);
    base_until(120);
    samp(8'd0);
    chk("f_off120", {15'd0, bit_valid}, 16'd0);
    base_until(143);
    samp(8'd62);
    chk("f_bv143", {15'd0, bit_valid}, 16'd1);

    // miss handling
    reset_dut();
    acquire();
    base_until(103);
    samp(8'd30);
    chk("m_miss103", {14'd0, miss_cnt}, 16'd1);
    chk("m_lk103", {15'd0, locked}, 16'd1);
    chk("m_bv103", {15'd0, bit_valid}, 16'd0);
    base_until(134);
    samp(8'd62);
    chk("m_miss134", {14'd0, miss_cnt}, 16'd0);
    chk("m_bv134", {15'd0, bit_valid}, 16'd1);
    base_until(165);
    samp(8'd31);
    chk("m_miss165", {14'd0, miss_cnt}, 16'd1);
    chk("m_st165", {14'd0, state}, 16'd2);
    base_until(196);
    samp(8'd31);
    chk("m_lk196", {15'd0, locked}, 16'd0);
    chk("m_st196", {14'd0, state}, 16'd0);
    chk("m_miss196", {14'd0, miss_cnt}, 16'd0);
    base_until(200);
    samp(8'd62);
    chk("m_st200", {14'd0, state}, 16'd1);

    // corr_en gaps with peaks inside are transparent
    reset_dut();
    base_until(10);
    samp(8'd62);
    gap(7);
    chk("g_st1", {14'd0, state}, 16'd1);
    base_until(41);
    samp(8'd62);
    gap(7);
    base_until(72);
    chk("g_lk71", {15'd0, locked}, 16'd0);
    samp(8'd62);
    chk("g_lk72", {15'd0, locked}, 16'd1);

    // asynchronous reset mid-lock
    reset_dut();
    acquire();
    base_until(103);
    samp(8'd30);
    chk("r_miss_pre", {14'd0, miss_cnt}, 16'd1);
    samp(8'd31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_lk", {15'd0, locked}, 16'd0);
    chk("r_st", {14'd0, state}, 16'd0);
    chk("r_miss", {14'd0, miss_cnt}, 16'd0);
    chk("r_bv", {15'd0, bit_valid}, 16'd0);
    rst_n = 1'b1;
    idx   = 0;
    base_until(5);
    samp(8'd62);
    chk("r_restart", {14'd0, state}, 16'd1);
    chk("r_restart_lk", {15'd0, locked}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
